// File: rtl/bcd_serial_source.sv
// Nibble FIFO feeding an MSB-first serializer that drives the recognizer's LINEA input.
// Optional even-parity fifth bit when BCD_SERIAL_SOURCE_PARITY_EN is defined.
module bcd_serial_source #(
    parameter int   DEPTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    input  logic       SHIFT_EN,
    output logic       LINEA,
    output logic       FRAME_START,
    output logic       BUSY
);

    localparam int AW = $clog2(DEPTH);

`ifdef BCD_SERIAL_SOURCE_PARITY_EN
    localparam logic [2:0] NBITS = 3'd5;
`else
    localparam logic [2:0] NBITS = 3'd4;
`endif

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t state, state_nx;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          push, pop, fifo_empty;
    logic [3:0]    head;

    logic [3:0] shreg, shreg_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic       line_nx, fs_nx;
    logic       fill_bit;

    assign fifo_empty = (count == '0);
    assign DIN_READY  = (count != (AW+1)'(DEPTH));
    assign push       = DIN_VALID & DIN_READY;
    assign head       = mem[rd_ptr];
    assign BUSY       = (state == S_SHIFT) || !fifo_empty;

`ifdef BCD_SERIAL_SOURCE_PARITY_EN
    assign fill_bit = ^head;
`else
    assign fill_bit = 1'b0;
`endif

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= DIN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            LINEA       <= IDLE_LEVEL;
            FRAME_START <= 1'b0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            bit_cnt     <= bit_cnt_nx;
            LINEA       <= line_nx;
            FRAME_START <= fs_nx;
        end
    end

    // Loading from IDLE and from the last bit of SHIFT are identical, giving gapless frames.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        line_nx    = LINEA;
        fs_nx      = FRAME_START;
        pop        = 1'b0;
        if (SHIFT_EN) begin
            if (state == S_SHIFT && bit_cnt != NBITS) begin
                line_nx    = shreg[3];
                shreg_nx   = {shreg[2:0], 1'b0};
                bit_cnt_nx = bit_cnt + 1'b1;
                fs_nx      = 1'b0;
            end else if (!fifo_empty) begin
                pop        = 1'b1;
                line_nx    = head[3];
                shreg_nx   = {head[2:0], fill_bit};
                bit_cnt_nx = 3'd1;
                fs_nx      = 1'b1;
                state_nx   = S_SHIFT;
            end else begin
                line_nx    = IDLE_LEVEL;
                fs_nx      = 1'b0;
                state_nx   = S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_source.sv
// Scoreboard bench for bcd_serial_source: accepted nibbles queue expected bits, a
// negedge monitor pops and compares them against LINEA/FRAME_START.
module tb_bcd_serial_source;

    localparam int   DEPTH      = 4;
    localparam logic IDLE_LEVEL = 1'b0;
`ifdef BCD_SERIAL_SOURCE_PARITY_EN
    localparam int NBITS = 5;
`else
    localparam int NBITS = 4;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] DIN = '0;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic       SHIFT_EN = 1'b0;
    logic       LINEA;
    logic       FRAME_START;
    logic       BUSY;

    bcd_serial_source #(.DEPTH(DEPTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clock(clock), .reset(reset), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .SHIFT_EN(SHIFT_EN), .LINEA(LINEA),
        .FRAME_START(FRAME_START), .BUSY(BUSY)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic sbq[$];
    int   cyc = 0;
    logic en_prev = 1'b0;
    logic mon_en = 1'b0;
    int   bits_left = 0;
    logic last_line = IDLE_LEVEL;
    logic last_fs = 1'b0;
    int   frames = 0;
    int   gaps = 0;
    logic in_run = 1'b0;
    int   fs_cyc = 0;
    int   push_cyc = 0;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        en_prev <= SHIFT_EN;
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (!en_prev) begin
                check("hold_line", 32'(LINEA), 32'(last_line));
                check("hold_fs", 32'(FRAME_START), 32'(last_fs));
            end else if (bits_left > 0) begin
                if (sbq.size() == 0) begin
                    check("bit_underflow", 32'd1, 32'd0);
                end else begin
                    check("bit", 32'(LINEA), 32'(sbq.pop_front()));
                end
                check("fs_mid", 32'(FRAME_START), 32'd0);
                bits_left--;
                if (bits_left == 0) in_run = 1'b1;
            end else if (FRAME_START) begin
                if (sbq.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    check("first_bit", 32'(LINEA), 32'(sbq.pop_front()));
                end
                bits_left = NBITS - 1;
                frames++;
                fs_cyc = cyc;
            end else begin
                check("idle_line", 32'(LINEA), 32'(IDLE_LEVEL));
                if (in_run && sbq.size() > 0) gaps++;
                if (sbq.size() == 0) in_run = 1'b0;
            end
            last_line = LINEA;
            last_fs   = FRAME_START;
        end
    end

    task automatic expect_nibble(input logic [3:0] n);
        for (int i = 3; i >= 0; i--) sbq.push_back(n[i]);
`ifdef BCD_SERIAL_SOURCE_PARITY_EN
        sbq.push_back(^n);
`endif
    endtask

    // One push attempt; returns whether the handshake completed.
    task automatic push(input logic [3:0] n, output logic acc);
        @(negedge clock);
        DIN       = n;
        DIN_VALID = 1'b1;
        #1;
        acc = DIN_READY;
        @(posedge clock);
        if (acc) expect_nibble(n);
        #1;
        push_cyc = cyc;
    endtask

    task automatic push_end();
        @(negedge clock);
        DIN_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sbq.size() != 0 || bits_left != 0 || BUSY) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        sbq.delete();
        bits_left = 0;
        in_run    = 1'b0;
        last_line = IDLE_LEVEL;
        last_fs   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        last_line = LINEA;
        last_fs   = FRAME_START;
        mon_en    = 1'b1;
    endtask

    logic acc;
    int   nacc;
    logic [3:0] seq4 [4];

    initial begin
        seq4[0] = 4'h3; seq4[1] = 4'h7; seq4[2] = 4'h5; seq4[3] = 4'h9;

        // reset state
        #2;
        check("rst_line", 32'(LINEA), 32'(IDLE_LEVEL));
        check("rst_fs", 32'(FRAME_START), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_ready", 32'(DIN_READY), 32'd1);
        SHIFT_EN = 1'b1;
        do_reset();

        // single nibble, latency of one edge to first bit
        push(4'b1001, acc);
        push_end();
        check("t1_acc", 32'(acc), 32'd1);
        wait_drain("t1_drain");
        check("t1_latency", 32'(fs_cyc - push_cyc), 32'd1);
        check("t1_busy", 32'(BUSY), 32'd0);
        check("t1_line", 32'(LINEA), 32'(IDLE_LEVEL));

        // back-to-back nibbles with no gap
        frames = 0;
        gaps   = 0;
        for (int i = 0; i < 4; i++) push(seq4[i], acc);
        push_end();
        wait_drain("t2_drain");
        check("t2_frames", 32'(frames), 32'd4);
        check("t2_gaps", 32'(gaps), 32'd0);

        // fill while frozen; extra nibble refused
        @(negedge clock);
        SHIFT_EN = 1'b0;
        frames = 0;
        nacc   = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            push(4'(i + 1), acc);
            if (acc) nacc++;
        end
        push_end();
        check("t3_accepts", 32'(nacc), 32'(DEPTH));
        check("t3_ready", 32'(DIN_READY), 32'd0);
        check("t3_busy", 32'(BUSY), 32'd1);
        repeat (3) @(negedge clock);
        SHIFT_EN = 1'b1;
        wait_drain("t3_drain");
        check("t3_frames", 32'(frames), 32'(DEPTH));

        // toggling enable during 0xA
        push(4'hA, acc);
        push_end();
        for (int i = 0; i < 16; i++) begin
            SHIFT_EN = i[0] ? 1'b0 : 1'b1;
            @(negedge clock);
        end
        SHIFT_EN = 1'b1;
        wait_drain("t4_drain");

        // random nibbles under random enable
        for (int i = 0; i < 10; i++) begin
            push(4'($urandom_range(0, 15)), acc);
            SHIFT_EN = 1'($urandom_range(0, 1));
        end
        push_end();
        SHIFT_EN = 1'b1;
        wait_drain("t5_drain");

        // reset mid-nibble discards partial and queued nibbles
        push(4'hC, acc);
        push(4'h1, acc);
        push(4'h2, acc);
        push_end();
        nacc = 0;
        while (bits_left != NBITS - 2 && nacc < 50) begin
            @(negedge clock);
            nacc++;
        end
        check("t6_reach", 32'(nacc < 50), 32'd1);
        #2;
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        check("t6_line", 32'(LINEA), 32'(IDLE_LEVEL));
        check("t6_fs", 32'(FRAME_START), 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
        check("t6_ready", 32'(DIN_READY), 32'd1);
        sbq.delete();
        bits_left = 0;
        in_run    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        last_line = LINEA;
        last_fs   = FRAME_START;
        frames    = 0;
        mon_en    = 1'b1;
        repeat (12) @(negedge clock);
        check("t6_no_frames", 32'(frames), 32'd0);
        check("t6_busy_after", 32'(BUSY), 32'd0);

`ifdef BCD_SERIAL_SOURCE_PARITY_EN
        push(4'h7, acc);
        push(4'h9, acc);
        push_end();
        wait_drain("t7_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_source.md
Name: bcd_serial_source

Overview:
- Upstream feeder for the serial BCD-recognizer stage.
- Accepts 4-bit nibbles over a valid/ready handshake and buffers them in a small FIFO.
- Drives them MSB-first, one bit per enabled clock, on a single registered serial line (connects directly to the recognizer's LINEA input).
- Also supplies a frame-start strobe and a busy flag for bench and debug alignment.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
IDLE_LEVEL, 1'b0, value driven on LINEA when no nibble is being shifted

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
DIN  input  4  nibble to send; bit 3 is sent first
DIN_VALID  input  1  DIN is valid this cycle
DIN_READY  output  1  FIFO can accept; combinational, = (fifo_count != DEPTH)
SHIFT_EN  input  1  advance serializer this cycle; low freezes shift path only
LINEA  output  1  registered serial bit stream
FRAME_START  output  1  registered; high exactly while LINEA carries bit 3 of a nibble
BUSY  output  1  high when state is SHIFT or FIFO is non-empty

Behaviour:
Reset:
- LINEA=IDLE_LEVEL, FRAME_START=0, state=IDLE, fifo_count=0, rd/wr pointers=0, bit_cnt=0.
- Reset is asynchronous and takes effect mid-nibble: the partial nibble and all FIFO contents are discarded.
FIFO:
- Push on DIN_VALID & DIN_READY.
- Pop is internal.
- Push and pop in the same cycle: count unchanged; both pointers advance, wrapping modulo DEPTH.
- Push while full is impossible, since READY is low.
- Data pushed at edge T is poppable no earlier than edge T+1 (no fall-through).
State machine (all transitions gated by SHIFT_EN=1; with SHIFT_EN=0 state, shreg, bit_cnt, LINEA and FRAME_START hold, and the FIFO still accepts pushes):
- IDLE, FIFO empty: LINEA<=IDLE_LEVEL, FRAME_START<=0.
- IDLE, FIFO non-empty: pop; LINEA<=nib[3]; shreg<={nib[2:0],0}; bit_cnt<=1; FRAME_START<=1; go to SHIFT.
- SHIFT, bit_cnt < NBITS: LINEA<=shreg msb; shift left; bit_cnt++; FRAME_START<=0.
- SHIFT, bit_cnt == NBITS (last bit currently on LINEA), FIFO non-empty: load the next nibble exactly as from IDLE (back-to-back, zero gap cycles).
- SHIFT, bit_cnt == NBITS, FIFO empty: LINEA<=IDLE_LEVEL, FRAME_START<=0, go to IDLE.
Bit count and latency:
- NBITS=4 (5 with the optional feature).
- Latency: nibble pushed at edge T into an empty, idle block appears on LINEA starting after edge T+1, and occupies NBITS consecutive enabled cycles.
BUSY is combinational from state and count.

Optional Feature:
- Macro: BCD_SERIAL_SOURCE_PARITY_EN.
- Defined: NBITS=5. After bit 0, a fifth bit equal to the XOR of the 4 nibble bits (even parity) is shifted out, with FRAME_START timing unchanged.
- Not defined: NBITS=4 and no parity logic is generated.

Test Plan:
- Reset, then push 4'b1001 at edge 1 with SHIFT_EN=1 -> LINEA=1,0,0,1 over cycles after edges 2..5, FRAME_START high only after edge 2, then LINEA=IDLE_LEVEL and BUSY=0.
- Push 0x3, 0x7, 0x5, 0x9 on consecutive cycles -> 16 contiguous bits 0011 0111 0101 1001; FRAME_START pulses every 4th cycle; no idle gap.
- Hold SHIFT_EN=0 after DEPTH+1 push attempts -> DIN_READY=0 after DEPTH accepts, extra nibble not stored; release SHIFT_EN -> exactly DEPTH nibbles are emitted in order.
- Toggle SHIFT_EN 1,0,1,0 during nibble 0xA -> each bit of 1010 is held for the frozen cycles and no bit is lost or duplicated.
- Assert reset after the 2nd bit of 0xC with 2 nibbles queued -> LINEA=IDLE_LEVEL immediately, BUSY=0, DIN_READY=1; the queued nibbles are never sent.
- With BCD_SERIAL_SOURCE_PARITY_EN, push 0x7 -> LINEA=0,1,1,1,1 (parity 1), and 0x9 -> 1,0,0,1,0.
